ybus_arbiter: RTL and testbench

- Shares one downstream Y-bus consumer between two write_buffer instances, each presenting a 4-phase YREQ/YACK handshake with YDATA/YPARITY.
- Selects a requester round-robin, forwards its word on the Z side, checks parity against the common PARITYSEL, and completes the upstream handshake only after the downstream consumer has acknowledged.
- Sits between the write buffers and the memory-side consumer.
- Also drives PARITYSEL to both buffers from a configuration input.

---
 rtl/ybus_arbiter_if.sv | 40 ++++
 rtl/ybus_arbiter.sv | 115 +++++++++++
 tb/tb_ybus_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ybus_arbiter_if.sv
// ybus_arbiter_if: bundle of all Y-side, Z-side and configuration signals of
// the two-buffer Y-bus arbiter.
//   master : arbiter view (drives YACKx, ZREQ/ZDATA/ZPARITY/ZSRC, PARITYSEL,
//            PERR, ERRCNT; samples YREQx/YDATAx/YPARITYx, ZACK, CFG, ERRCLR)
//   slave  : environment view (write buffers, consumer, configuration)
interface ybus_arbiter_if #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ERRCNT_W = 8
);
   logic                CFG_PARITYSEL;
   logic                PARITYSEL;
   logic                YREQ0;
   logic [DATA_W-1:0]   YDATA0;
   logic                YPARITY0;
   logic                YACK0;
   logic                YREQ1;
   logic [DATA_W-1:0]   YDATA1;
   logic                YPARITY1;
   logic                YACK1;
   logic                ZREQ;
   logic [DATA_W-1:0]   ZDATA;
   logic                ZPARITY;
   logic                ZSRC;
   logic                ZACK;
   logic                PERR;
   logic [ERRCNT_W-1:0] ERRCNT;
   logic                ERRCLR;

   modport master (
      input  CFG_PARITYSEL, YREQ0, YDATA0, YPARITY0, YREQ1, YDATA1, YPARITY1,
             ZACK, ERRCLR,
      output PARITYSEL, YACK0, YACK1, ZREQ, ZDATA, ZPARITY, ZSRC, PERR, ERRCNT
   );

   modport slave (
      output CFG_PARITYSEL, YREQ0, YDATA0, YPARITY0, YREQ1, YDATA1, YPARITY1,
             ZACK, ERRCLR,
      input  PARITYSEL, YACK0, YACK1, ZREQ, ZDATA, ZPARITY, ZSRC, PERR, ERRCNT
   );
endinterface

// File: rtl/ybus_arbiter.sv
// ybus_arbiter: round-robin arbiter sharing one downstream Z-bus consumer
// between two write buffers using 4-phase YREQ/YACK handshakes. The granted
// word is forwarded on the Z side, its parity is checked against PARITYSEL,
// and the upstream YACK is raised only after the consumer has acknowledged.
// Ports:
//   clk  - system clock, posedge
//   rst  - asynchronous active-high reset
//   bus  - ybus_arbiter_if.master (Y side, Z side, parity config, error count)
module ybus_arbiter #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ERRCNT_W = 8
) (
   input logic           clk,
   input logic           rst,
   ybus_arbiter_if.master bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FWD  = 2'd1,
      RET  = 2'd2
   } state_t;

   state_t              state;
   logic                last;

   logic                sel_c;
   logic [DATA_W-1:0]   sel_data_c;
   logic                sel_par_c;
   logic                grant_c;
   logic                exp_par_c;
   logic                mismatch_c;
   logic                sel_req_c;
   logic [ERRCNT_W-1:0] cnt_base_c;
   logic [ERRCNT_W-1:0] cnt_next_c;

   // Request selection, parity check and saturating error-count update
   always_comb begin
      sel_c = 1'b0;
      if (bus.YREQ0 && bus.YREQ1) begin
         sel_c = ~last;
      end else if (bus.YREQ1) begin
         sel_c = 1'b1;
      end
      sel_data_c = sel_c ? bus.YDATA1 : bus.YDATA0;
      sel_par_c  = sel_c ? bus.YPARITY1 : bus.YPARITY0;
      // A consumer still holding ZACK in IDLE blocks any new grant
      grant_c    = (state == IDLE) && (bus.YREQ0 || bus.YREQ1) && !bus.ZACK;
      exp_par_c  = bus.PARITYSEL ? ~^sel_data_c : ^sel_data_c;
      mismatch_c = grant_c && (sel_par_c != exp_par_c);
      // Clear takes effect before the count, so clear+error yields 1
      cnt_base_c = bus.ERRCLR ? '0 : bus.ERRCNT;
      cnt_next_c = cnt_base_c;
      if (mismatch_c && (cnt_base_c != {ERRCNT_W{1'b1}})) begin
         cnt_next_c = cnt_base_c + ERRCNT_W'(1);
      end
      // Request line of the requester currently being served
      sel_req_c  = bus.ZSRC ? bus.YREQ1 : bus.YREQ0;
   end

   // Arbitration FSM with registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         last          <= 1'b1;
         bus.PARITYSEL <= 1'b0;
         bus.YACK0     <= 1'b0;
         bus.YACK1     <= 1'b0;
         bus.ZREQ      <= 1'b0;
         bus.ZDATA     <= '0;
         bus.ZPARITY   <= 1'b0;
         bus.ZSRC      <= 1'b0;
         bus.PERR      <= 1'b0;
         bus.ERRCNT    <= '0;
      end else begin
         bus.PERR   <= 1'b0;
         bus.ERRCNT <= cnt_next_c;
         case (state)
            IDLE: begin
               bus.PARITYSEL <= bus.CFG_PARITYSEL;
               if (grant_c) begin
                  bus.ZDATA   <= sel_data_c;
                  bus.ZPARITY <= sel_par_c;
                  bus.ZSRC    <= sel_c;
                  bus.ZREQ    <= 1'b1;
                  bus.PERR    <= mismatch_c;
                  state       <= FWD;
               end
            end
            FWD: begin
               if (bus.ZACK) begin
                  bus.ZREQ <= 1'b0;
                  if (bus.ZSRC) begin
                     bus.YACK1 <= 1'b1;
                  end else begin
                     bus.YACK0 <= 1'b1;
                  end
                  state <= RET;
               end
            end
            RET: begin
               // Both sides must have released, in any order
               if (!bus.ZACK && !sel_req_c) begin
                  bus.YACK0 <= 1'b0;
                  bus.YACK1 <= 1'b0;
                  last      <= bus.ZSRC;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ybus_arbiter.sv
// tb_ybus_arbiter: directed testbench for ybus_arbiter. Each task drives one
// scenario cycle by cycle and compares outputs against hand-derived values.
module tb_ybus_arbiter;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   ybus_arbiter_if #(.DATA_W(32), .ERRCNT_W(8)) bus();

   ybus_arbiter #(.DATA_W(32), .ERRCNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.CFG_PARITYSEL = 1'b0;
      bus.YREQ0 = 1'b0; bus.YDATA0 = '0; bus.YPARITY0 = 1'b0;
      bus.YREQ1 = 1'b0; bus.YDATA1 = '0; bus.YPARITY1 = 1'b0;
      bus.ZACK = 1'b0;  bus.ERRCLR = 1'b0;
   endtask

   task automatic apply_reset();
      clear_inputs();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      #1;
      vectors++;
      if ({bus.YACK0, bus.YACK1, bus.ZREQ, bus.ZPARITY, bus.ZSRC, bus.PERR, bus.PARITYSEL} !== 7'b0) begin
         miscompares++;
         $display("FAIL reset_ctrl got %b want 0000000",
                  {bus.YACK0, bus.YACK1, bus.ZREQ, bus.ZPARITY, bus.ZSRC, bus.PERR, bus.PARITYSEL});
      end
      vectors++;
      if (bus.ZDATA !== 32'h0 || bus.ERRCNT !== 8'h0) begin
         miscompares++;
         $display("FAIL reset_data got zdata=%h errcnt=%h want 0/0", bus.ZDATA, bus.ERRCNT);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_single();
      apply_reset();
      bus.YREQ0 = 1'b1; bus.YDATA0 = 32'h0000_0003; bus.YPARITY0 = 1'b0;
      tick();
      vectors++;
      if (bus.ZREQ !== 1'b1 || bus.ZDATA !== 32'h3 || bus.ZSRC !== 1'b0 || bus.PERR !== 1'b0) begin
         miscompares++;
         $display("FAIL single_grant got zreq=%b zdata=%h zsrc=%b perr=%b want 1/3/0/0",
                  bus.ZREQ, bus.ZDATA, bus.ZSRC, bus.PERR);
      end
      tick();
      bus.ZACK = 1'b1;
      vectors++;
      if (bus.ZREQ !== 1'b1 || bus.YACK0 !== 1'b0) begin
         miscompares++;
         $display("FAIL single_hold got zreq=%b yack0=%b want 1/0", bus.ZREQ, bus.YACK0);
      end
      tick();
      vectors++;
      if (bus.YACK0 !== 1'b1 || bus.ZREQ !== 1'b0 || bus.YACK1 !== 1'b0) begin
         miscompares++;
         $display("FAIL single_ack got yack0=%b zreq=%b yack1=%b want 1/0/0",
                  bus.YACK0, bus.ZREQ, bus.YACK1);
      end
      bus.YREQ0 = 1'b0; bus.ZACK = 1'b0;
      tick();
      vectors++;
      if (bus.YACK0 !== 1'b0) begin
         miscompares++;
         $display("FAIL single_release got yack0=%b want 0", bus.YACK0);
      end
   endtask

   task automatic test_round_robin();
      logic [1:0] yack;
      logic       exp;
      apply_reset();
      bus.YDATA0 = 32'h0000_0003; bus.YPARITY0 = 1'b0;
      bus.YDATA1 = 32'h0000_0007; bus.YPARITY1 = 1'b1;
      bus.YREQ0 = 1'b1; bus.YREQ1 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp = k[0];
         tick();
         vectors++;
         if (bus.ZSRC !== exp || bus.ZREQ !== 1'b1 ||
             bus.ZDATA !== (exp ? 32'h7 : 32'h3) || bus.PERR !== 1'b0) begin
            miscompares++;
            $display("FAIL rr_grant%0d got zsrc=%b zreq=%b zdata=%h perr=%b want zsrc=%b",
                     k, bus.ZSRC, bus.ZREQ, bus.ZDATA, bus.PERR, exp);
         end
         bus.ZACK = 1'b1;
         tick();
         yack = {bus.YACK1, bus.YACK0};
         vectors++;
         if (yack !== (exp ? 2'b10 : 2'b01)) begin
            miscompares++;
            $display("FAIL rr_ack%0d got yack=%b want %b", k, yack, exp ? 2'b10 : 2'b01);
         end
         if (exp) bus.YREQ1 = 1'b0; else bus.YREQ0 = 1'b0;
         bus.ZACK = 1'b0;
         tick();
         if (exp) bus.YREQ1 = 1'b1; else bus.YREQ0 = 1'b1;
      end
      bus.YREQ0 = 1'b0; bus.YREQ1 = 1'b0;
   endtask

   task automatic test_parity_error();
      apply_reset();
      bus.CFG_PARITYSEL = 1'b1;
      tick();
      vectors++;
      if (bus.PARITYSEL !== 1'b1) begin
         miscompares++;
         $display("FAIL paritysel_idle got %b want 1", bus.PARITYSEL);
      end
      bus.YREQ1 = 1'b1; bus.YDATA1 = 32'h1; bus.YPARITY1 = 1'b1;
      tick();
      vectors++;
      if (bus.PERR !== 1'b1 || bus.ERRCNT !== 8'd1 || bus.ZDATA !== 32'h1 ||
          bus.ZSRC !== 1'b1 || bus.ZPARITY !== 1'b1) begin
         miscompares++;
         $display("FAIL perr_grant got perr=%b errcnt=%h zdata=%h zsrc=%b zpar=%b want 1/01/1/1/1",
                  bus.PERR, bus.ERRCNT, bus.ZDATA, bus.ZSRC, bus.ZPARITY);
      end
      bus.CFG_PARITYSEL = 1'b0;
      tick();
      vectors++;
      if (bus.PERR !== 1'b0 || bus.PARITYSEL !== 1'b1 || bus.ERRCNT !== 8'd1) begin
         miscompares++;
         $display("FAIL perr_pulse got perr=%b paritysel=%b errcnt=%h want 0/1/01",
                  bus.PERR, bus.PARITYSEL, bus.ERRCNT);
      end
      bus.ZACK = 1'b1;
      tick();
      bus.YREQ1 = 1'b0; bus.ZACK = 1'b0;
      tick();
      bus.ERRCLR = 1'b1;
      tick();
      bus.ERRCLR = 1'b0;
      vectors++;
      if (bus.ERRCNT !== 8'd0 || bus.PARITYSEL !== 1'b0) begin
         miscompares++;
         $display("FAIL errclr got errcnt=%h paritysel=%b want 00/0", bus.ERRCNT, bus.PARITYSEL);
      end
      // Even parity: data 1 needs parity 1, so parity 0 is a mismatch
      bus.YREQ0 = 1'b1; bus.YDATA0 = 32'h1; bus.YPARITY0 = 1'b0;
      tick();
      bus.ZACK = 1'b1;
      tick();
      bus.YREQ0 = 1'b0; bus.ZACK = 1'b0;
      tick();
      bus.YREQ0 = 1'b1; bus.ERRCLR = 1'b1;
      tick();
      bus.ERRCLR = 1'b0;
      vectors++;
      if (bus.ERRCNT !== 8'd1 || bus.PERR !== 1'b1) begin
         miscompares++;
         $display("FAIL clr_and_err got errcnt=%h perr=%b want 01/1", bus.ERRCNT, bus.PERR);
      end
      bus.ZACK = 1'b1;
      tick();
      bus.YREQ0 = 1'b0; bus.ZACK = 1'b0;
      tick();
   endtask

   task automatic test_saturation();
      apply_reset();
      bus.YDATA0 = 32'h1; bus.YPARITY0 = 1'b0;
      for (int i = 0; i < 260; i++) begin
         bus.YREQ0 = 1'b1;
         tick();
         bus.ZACK = 1'b1;
         tick();
         bus.YREQ0 = 1'b0; bus.ZACK = 1'b0;
         tick();
         if (i == 253) begin
            vectors++;
            if (bus.ERRCNT !== 8'hFE) begin
               miscompares++;
               $display("FAIL sat_254 got errcnt=%h want fe", bus.ERRCNT);
            end
         end
      end
      vectors++;
      if (bus.ERRCNT !== 8'hFF) begin
         miscompares++;
         $display("FAIL sat_260 got errcnt=%h want ff", bus.ERRCNT);
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      bus.YREQ0 = 1'b1; bus.YDATA0 = 32'h3;
      tick();
      #2;
      rst = 1'b1;
      #1;
      vectors++;
      if (bus.ZREQ !== 1'b0 || bus.YACK0 !== 1'b0 || bus.YACK1 !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_fwd got zreq=%b yack0=%b yack1=%b want 0/0/0",
                  bus.ZREQ, bus.YACK0, bus.YACK1);
      end
      bus.YREQ0 = 1'b0; bus.YREQ1 = 1'b1; bus.YDATA1 = 32'h7; bus.YPARITY1 = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
      vectors++;
      if (bus.ZSRC !== 1'b1 || bus.ZREQ !== 1'b1 || bus.ZDATA !== 32'h7) begin
         miscompares++;
         $display("FAIL rst_regrant1 got zsrc=%b zreq=%b zdata=%h want 1/1/7",
                  bus.ZSRC, bus.ZREQ, bus.ZDATA);
      end
      bus.ZACK = 1'b1;
      tick();
      #2;
      rst = 1'b1;
      #1;
      vectors++;
      if (bus.YACK1 !== 1'b0 || bus.ZSRC !== 1'b0 || bus.ZDATA !== 32'h0) begin
         miscompares++;
         $display("FAIL rst_ret got yack1=%b zsrc=%b zdata=%h want 0/0/0",
                  bus.YACK1, bus.ZSRC, bus.ZDATA);
      end
      bus.ZACK = 1'b0; bus.YREQ0 = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
      vectors++;
      if (bus.ZSRC !== 1'b0 || bus.ZREQ !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_regrant_tie got zsrc=%b zreq=%b want 0/1", bus.ZSRC, bus.ZREQ);
      end
   endtask

   task automatic test_release_order();
      apply_reset();
      bus.YREQ0 = 1'b1; bus.YDATA0 = 32'h3;
      tick();
      bus.ZACK = 1'b1;
      tick();
      bus.YREQ0 = 1'b0;
      bus.YREQ1 = 1'b1; bus.YDATA1 = 32'h7; bus.YPARITY1 = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         vectors++;
         if (bus.YACK0 !== 1'b1 || bus.ZREQ !== 1'b0 || bus.YACK1 !== 1'b0) begin
            miscompares++;
            $display("FAIL ret_hold%0d got yack0=%b zreq=%b yack1=%b want 1/0/0",
                     c, bus.YACK0, bus.ZREQ, bus.YACK1);
         end
      end
      bus.ZACK = 1'b0;
      tick();
      vectors++;
      if (bus.YACK0 !== 1'b0 || bus.ZREQ !== 1'b0) begin
         miscompares++;
         $display("FAIL ret_drop got yack0=%b zreq=%b want 0/0", bus.YACK0, bus.ZREQ);
      end
      tick();
      vectors++;
      if (bus.ZREQ !== 1'b1 || bus.ZSRC !== 1'b1) begin
         miscompares++;
         $display("FAIL ret_next got zreq=%b zsrc=%b want 1/1", bus.ZREQ, bus.ZSRC);
      end
   endtask

   task automatic test_stuck_zack();
      apply_reset();
      bus.ZACK = 1'b1; bus.YREQ0 = 1'b1; bus.YDATA0 = 32'h3;
      tick();
      tick();
      vectors++;
      if (bus.ZREQ !== 1'b0 || bus.YACK0 !== 1'b0) begin
         miscompares++;
         $display("FAIL zack_idle got zreq=%b yack0=%b want 0/0", bus.ZREQ, bus.YACK0);
      end
      bus.ZACK = 1'b0;
      tick();
      vectors++;
      if (bus.ZREQ !== 1'b1 || bus.ZSRC !== 1'b0) begin
         miscompares++;
         $display("FAIL zack_release got zreq=%b zsrc=%b want 1/0", bus.ZREQ, bus.ZSRC);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      clear_inputs();
      test_reset();
      test_single();
      test_round_robin();
      test_parity_error();
      test_saturation();
      test_reset_mid();
      test_release_order();
      test_stuck_zack();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
